// File: rtl/y86_front_end.sv
// rtl/y86_front_end.sv - Y86-64 fetch/decode/execute front end with imem and CC register
module y86_front_end #(
   parameter int IMEM_BYTES = 2048
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] PC,
   input  logic        imem_we,
   input  logic [10:0] imem_waddr,
   input  logic [7:0]  imem_wdata,
   input  logic [63:0] regA_val,
   input  logic [63:0] regB_val,
   input  logic [63:0] stk_val,
   output logic [3:0]  icode,
   output logic [3:0]  ifun,
   output logic [3:0]  rA,
   output logic [3:0]  rB,
   output logic [63:0] valC,
   output logic [63:0] valP,
   output logic [63:0] valA,
   output logic [63:0] valB,
   output logic [63:0] valE,
   output logic        zf,
   output logic        sf,
   output logic        of,
   output logic        cnd,
   output logic        inst_valid,
   output logic        imem_er,
   output logic        hlt_er
);

   logic [7:0]  mem [IMEM_BYTES];
   logic [63:0] fa [10];
   logic [7:0]  fb [10];
   logic [3:0]  len;
   logic [64:0] end_addr;
   logic        of_n;
   logic        cc_en;
   logic        zf_d, sf_d, of_d;
   logic        zf_q, sf_q, of_q;

   // loader writes one byte per clock; contents are never reset
   always_ff @(posedge clk) begin
      if (imem_we && ({53'd0, imem_waddr} < 64'(IMEM_BYTES))) mem[imem_waddr] <= imem_wdata;
   end

   // fetch the ten bytes at PC; bytes past the end of imem read as zero
   always_comb begin
      for (int i = 0; i < 10; i++) begin
         fa[i] = PC + 64'(i);
         fb[i] = (fa[i] < 64'(IMEM_BYTES)) ? mem[fa[i][10:0]] : 8'h00;
      end
   end

   // split the instruction fields and work out its length and legality
   always_comb begin
      icode = fb[0][7:4];
      ifun  = fb[0][3:0];
      rA    = 4'hF;
      rB    = 4'hF;
      valC  = '0;
      len   = 4'd1;
      case (icode)
         4'h2, 4'h6, 4'hA, 4'hB: begin
            rA = fb[1][7:4]; rB = fb[1][3:0]; len = 4'd2;
         end
         4'h3, 4'h4, 4'h5: begin
            rA = fb[1][7:4]; rB = fb[1][3:0]; len = 4'd10;
            valC = {fb[9], fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2]};
         end
         4'h7, 4'h8: begin
            len = 4'd9;
            valC = {fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2], fb[1]};
         end
         default: ;
      endcase
      valP     = PC + 64'(len);
      end_addr = {1'b0, PC} + 65'(len) - 65'd1;
      imem_er  = end_addr >= 65'(IMEM_BYTES);
      hlt_er   = (icode == 4'h0);
      case (icode)
         4'h2, 4'h7: inst_valid = (ifun <= 4'd6);
         4'h6:       inst_valid = (ifun <= 4'd3);
         4'hC, 4'hD, 4'hE, 4'hF: inst_valid = 1'b0;
         default:    inst_valid = (ifun == 4'd0);
      endcase
   end

   // operand selection from the regfile read values
   always_comb begin
      case (icode)
         4'h2, 4'h4, 4'h6, 4'hA: valA = regA_val;
         4'h9, 4'hB:             valA = stk_val;
         default:                valA = '0;
      endcase
      case (icode)
         4'h4, 4'h5, 4'h6:       valB = regB_val;
         4'h8, 4'h9, 4'hA, 4'hB: valB = stk_val;
         default:                valB = '0;
      endcase
   end

   // ALU; illegal instructions behave as nop and produce zero
   always_comb begin
      valE = '0;
      of_n = 1'b0;
      if (inst_valid) begin
         case (icode)
            4'h2:       valE = valA;
            4'h3:       valE = valC;
            4'h4, 4'h5: valE = valB + valC;
            4'h6: begin
               case (ifun)
                  4'h0: begin
                     valE = valB + valA;
                     of_n = (valA[63] == valB[63]) && (valE[63] != valA[63]);
                  end
                  4'h1: begin
                     valE = valB - valA;
                     of_n = (valA[63] != valB[63]) && (valE[63] != valB[63]);
                  end
                  4'h2:    valE = valB & valA;
                  default: valE = valB ^ valA;
               endcase
            end
            4'h8, 4'hA: valE = valB - 64'd8;
            4'h9, 4'hB: valE = valB + 64'd8;
            default:    valE = '0;
         endcase
      end
   end

   // next CC value: only a legal, fully fetched OPq changes the flags
   always_comb begin
      cc_en = inst_valid && (icode == 4'h6) && !imem_er && !hlt_er;
      zf_d  = zf_q;
      sf_d  = sf_q;
      of_d  = of_q;
      if (cc_en) begin
         zf_d = (valE == 64'd0);
         sf_d = valE[63];
         of_d = of_n;
      end
   end

   // condition-code register, cleared to zf=1 as soon as reset asserts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zf_q <= 1'b1;
         sf_q <= 1'b0;
         of_q <= 1'b0;
      end else begin
         zf_q <= zf_d;
         sf_q <= sf_d;
         of_q <= of_d;
      end
   end

   // branch/cmov condition from the stored flags
   always_comb begin
      zf  = zf_q;
      sf  = sf_q;
      of  = of_q;
      cnd = 1'b0;
      if (icode == 4'h2 || icode == 4'h7) begin
         case (ifun)
            4'h0: cnd = 1'b1;
            4'h1: cnd = (sf_q ^ of_q) | zf_q;
            4'h2: cnd = sf_q ^ of_q;
            4'h3: cnd = zf_q;
            4'h4: cnd = !zf_q;
            4'h5: cnd = !(sf_q ^ of_q);
            4'h6: cnd = !(sf_q ^ of_q) && !zf_q;
            default: cnd = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_y86_front_end.sv
// tb/tb_y86_front_end.sv - directed checks for y86_front_end
module tb_y86_front_end;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] PC;
   logic        imem_we;
   logic [10:0] imem_waddr;
   logic [7:0]  imem_wdata;
   logic [63:0] regA_val, regB_val, stk_val;
   logic [3:0]  icode, ifun, rA, rB;
   logic [63:0] valC, valP, valA, valB, valE;
   logic        zf, sf, of, cnd, inst_valid, imem_er, hlt_er;

   int tests = 0;
   int fails = 0;

   y86_front_end #(.IMEM_BYTES(2048)) dut (
      .clk(clk), .rst_n(rst_n), .PC(PC),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .regA_val(regA_val), .regB_val(regB_val), .stk_val(stk_val),
      .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
      .valC(valC), .valP(valP), .valA(valA), .valB(valB), .valE(valE),
      .zf(zf), .sf(sf), .of(of), .cnd(cnd),
      .inst_valid(inst_valid), .imem_er(imem_er), .hlt_er(hlt_er)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [10:0] a, input logic [7:0] d);
      @(negedge clk);
      imem_we    = 1'b1;
      imem_waddr = a;
      imem_wdata = d;
      @(posedge clk);
      #1;
      imem_we = 1'b0;
   endtask

   task automatic set_pc(input logic [63:0] p);
      @(negedge clk);
      PC = p;
      #1;
   endtask

   initial begin
      logic [7:0] prog [10];
      rst_n = 1'b0; PC = 64'd4000; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
      regA_val = '0; regB_val = '0; stk_val = '0;
      #12;
      check("rst_zf", zf, 1); check("rst_sf", sf, 0); check("rst_of", of, 0);
      // PC parked out of range: halt byte, fetch error
      check("oob_hlt", hlt_er, 1); check("oob_imem_er", imem_er, 1);
      rst_n = 1'b1;

      // irmovq $10, %rdx at 0
      prog = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 10; i++) wr(11'(i), prog[i]);
      // jump-style 73 with destination bytes 01..08 at 40
      prog = '{8'h73, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00};
      for (int i = 0; i < 9; i++) wr(11'(40 + i), prog[i]);
      wr(11'd16, 8'h60); wr(11'd17, 8'h01);
      wr(11'd18, 8'h72);
      wr(11'd32, 8'h61); wr(11'd33, 8'h23);
      wr(11'd64, 8'hA0); wr(11'd65, 8'h3F);
      wr(11'd70, 8'h90);
      wr(11'd80, 8'hC0);
      wr(11'd82, 8'h64); wr(11'd83, 8'h01);
      wr(11'd84, 8'h00);
      wr(11'd2038, 8'h30);
      wr(11'd2045, 8'h30);

      set_pc(64'd0);
      check("irm_icode", icode, 3); check("irm_ifun", ifun, 0);
      check("irm_rA", rA, 4'hF); check("irm_rB", rB, 2);
      check("irm_valC", valC, 10); check("irm_valP", valP, 10); check("irm_valE", valE, 10);
      check("irm_valid", inst_valid, 1); check("irm_imem_er", imem_er, 0); check("irm_hlt", hlt_er, 0);

      // addq overflow
      regA_val = 64'd1; regB_val = 64'h7FFF_FFFF_FFFF_FFFF;
      set_pc(64'd16);
      check("add_valE", valE, 64'h8000_0000_0000_0000);
      check("add_zf_before", zf, 1);
      @(posedge clk); @(negedge clk); #1;
      check("add_zf", zf, 0); check("add_sf", sf, 1); check("add_of", of, 1);
      set_pc(64'd18);
      check("jl_cnd", cnd, 0);

      // subq equal values
      regA_val = 64'd5; regB_val = 64'd5;
      set_pc(64'd32);
      check("sub_valE", valE, 0);
      @(posedge clk); @(negedge clk); #1;
      check("sub_zf", zf, 1); check("sub_sf", sf, 0); check("sub_of", of, 0);
      set_pc(64'd40);
      check("je_cnd", cnd, 1); check("je_valC", valC, 64'h0807_0605_0403_0201);
      check("je_valP", valP, 49);

      // pushq / ret
      regA_val = 64'd7; stk_val = 64'd100;
      set_pc(64'd64);
      check("push_rA", rA, 3); check("push_rB", rB, 4'hF);
      check("push_valA", valA, 7); check("push_valB", valB, 100);
      check("push_valE", valE, 92); check("push_valP", valP, 66);
      set_pc(64'd70);
      check("ret_valA", valA, 100); check("ret_valE", valE, 108); check("ret_valP", valP, 71);

      // illegal instructions leave CC alone
      set_pc(64'd80);
      check("c0_valid", inst_valid, 0); check("c0_valE", valE, 0);
      regA_val = 64'd1; regB_val = 64'h8000_0000_0000_0000;
      set_pc(64'd82);
      check("64_valid", inst_valid, 0); check("64_valE", valE, 0);
      @(posedge clk); @(negedge clk); #1;
      check("bad_zf", zf, 1); check("bad_sf", sf, 0); check("bad_of", of, 0);

      set_pc(64'd84);
      check("halt_hlt", hlt_er, 1); check("halt_valP", valP, 85);

      set_pc(64'd2038);
      check("edge_imem_er", imem_er, 0);
      set_pc(64'd2045);
      check("over_imem_er", imem_er, 1);

      // reset mid-run takes effect without a clock edge
      regA_val = 64'd1; regB_val = 64'h7FFF_FFFF_FFFF_FFFF;
      set_pc(64'd16);
      @(posedge clk); @(negedge clk); #1;
      check("pre_rst_zf", zf, 0);
      rst_n = 1'b0;
      #1;
      check("async_zf", zf, 1); check("async_sf", sf, 0); check("async_of", of, 0);
      rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
